// File: rtl/l15_arb_pkg.sv
// l15_arb_pkg: shared types and helpers for the L1.5 request port arbiter
package l15_arb_pkg;
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  localparam int MaxPorts = 256;
  function automatic logic [7:0] onehot_to_bin(input logic [MaxPorts-1:0] oh);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < MaxPorts; i++) b |= oh[i] ? 8'(i) : 8'd0;
    return b;
  endfunction
endpackage

// File: rtl/l15_req_port_arbiter_if.sv
// l15_req_port_arbiter_if: requester-side and downstream-side signals of the L1.5 request arbiter
interface l15_req_port_arbiter_if #(
  parameter int NumPorts = 6,
  parameter int PayloadWidth = 128
);
  localparam int PortIdWidth = $clog2(NumPorts);
  logic [NumPorts-1:0] req_valid_i, req_ready_o, req_last_i, starve_o;
  logic [NumPorts*PayloadWidth-1:0] req_data_i;
  logic out_valid_o, out_ready_i, out_last_o;
  logic [PayloadWidth-1:0] out_data_o;
  logic [PortIdWidth-1:0] out_portid_o;
  modport slave (
    input req_valid_i, req_last_i, req_data_i, out_ready_i,
    output req_ready_o, starve_o, out_valid_o, out_last_o, out_data_o, out_portid_o
  );
  modport master (
    output req_valid_i, req_last_i, req_data_i, out_ready_i,
    input req_ready_o, starve_o, out_valid_o, out_last_o, out_data_o, out_portid_o
  );
endinterface

// File: rtl/l15_arb_picker.sv
// l15_arb_picker: combinational fixed-priority / round-robin pick among valid ports
module l15_arb_picker
  import l15_arb_pkg::*;
#(
  parameter int NumPorts = 6,
  localparam int PortIdWidth = $clog2(NumPorts)
) (
  input  logic [NumPorts-1:0]    valid,
  input  logic [NumPorts-1:0]    starve,
  input  logic [PortIdWidth-1:0] ptr,
  input  arb_mode_e              mode,
  output logic [NumPorts-1:0]    gnt,
  output logic [PortIdWidth-1:0] idx
);
  logic [NumPorts-1:0] cand;
  int j;
  // scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    cand = |(valid & starve) ? valid & starve : valid;
    gnt = '0;
    j = 0;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      j = mode == ARB_RR ? (int'(ptr) + k) % NumPorts : k;
      if (mode == ARB_RR ? valid[j] : cand[j]) gnt = NumPorts'(1) << j;
    end
  end
  assign idx = PortIdWidth'(onehot_to_bin(MaxPorts'(gnt)));
endmodule

// File: rtl/l15_req_port_arbiter.sv
// l15_req_port_arbiter: N-port request arbiter with packet locking feeding a registered output slice
module l15_req_port_arbiter
  import l15_arb_pkg::*;
#(
  parameter int NumPorts = 6,
  parameter int PayloadWidth = 128,
  parameter int ArbMode = 0,
  parameter int StarveTh = 16
) (
  input logic clk_i,
  input logic rst_ni,
  l15_req_port_arbiter_if.slave bus
);
  localparam int PortIdWidth = $clog2(NumPorts);
  localparam int CntWidth = $clog2(StarveTh + 1);
  localparam arb_mode_e Mode = ArbMode == 1 ? ARB_RR : ARB_FIXED;
  arb_state_e state_q, state_d;
  logic [PortIdWidth-1:0] lock_q, lock_d, ptr_q, pick_idx, gidx, portid_q;
  logic [NumPorts-1:0] pick_gnt, grant, ready, hs_v, starve;
  logic [NumPorts-1:0][CntWidth-1:0] cnt_q;
  logic [PayloadWidth-1:0] data_q;
  logic valid_q, last_q, run_q, accept, hs, hs_last;
  l15_arb_picker #(.NumPorts(NumPorts)) u_picker (
    .valid(bus.req_valid_i),
    .starve(starve),
    .ptr(ptr_q),
    .mode(Mode),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      lock_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
    end
  always_comb begin
    state_d = hs ? (hs_last ? ARB_IDLE : ARB_LOCKED) : state_q;
    lock_d = hs ? gidx : lock_q;
  end
  // run_q keeps every ready low until the first edge out of reset
  always_comb begin
    grant = state_q == ARB_LOCKED ? NumPorts'(1) << lock_q : pick_gnt;
    gidx = state_q == ARB_LOCKED ? lock_q : pick_idx;
    accept = ~valid_q | bus.out_ready_i;
    ready = {NumPorts{accept & run_q}} & grant;
    hs_v = bus.req_valid_i & ready;
    hs = |hs_v;
    hs_last = bus.req_last_i[gidx];
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      run_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      portid_q <= '0;
      ptr_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) valid_q <= hs;
      if (hs) begin
        data_q <= bus.req_data_i[gidx*PayloadWidth +: PayloadWidth];
        last_q <= hs_last;
        portid_q <= gidx;
      end
      if (hs && hs_last) ptr_q <= gidx == PortIdWidth'(NumPorts - 1) ? '0 : gidx + 1'b1;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else
      for (int i = 0; i < NumPorts; i++)
        cnt_q[i] <= (!bus.req_valid_i[i] || hs_v[i]) ? '0 : cnt_q[i] + CntWidth'(!starve[i]);
  always_comb
    for (int i = 0; i < NumPorts; i++) starve[i] = cnt_q[i] == CntWidth'(StarveTh);
  assign bus.req_ready_o = ready;
  assign bus.starve_o = starve;
  assign bus.out_valid_o = valid_q;
  assign bus.out_data_o = data_q;
  assign bus.out_last_o = last_q;
  assign bus.out_portid_o = portid_q;
endmodule
